// File: rtl/bitfusion_pkg.sv
// Shared BitFusion types: precision modes, bundle sizes, brick shift helper.
package bitfusion_pkg;

    localparam int LANES = 16;
    localparam int N_2B  = 16;
    localparam int N_4B  = 4;
    localparam int N_8B  = 1;

    typedef enum logic [1:0] {
        PREC_2B = 2'b00,
        PREC_4B = 2'b01,
        PREC_8B = 2'b10
    } prec_e;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic prec_e norm_prec(input logic [1:0] p);
        case (p)
            2'b00:   return PREC_2B;
            2'b01:   return PREC_4B;
            default: return PREC_8B;
        endcase
    endfunction

    function automatic logic [3:0] last_slot(input prec_e p);
        case (p)
            PREC_2B: return 4'(N_2B - 1);
            PREC_4B: return 4'(N_4B - 1);
            default: return 4'(N_8B - 1);
        endcase
    endfunction

    // Left-shift for brick (row i, column j).
    function automatic logic [3:0] brick_shift(input prec_e p,
                                               input logic [1:0] i,
                                               input logic [1:0] j);
        case (p)
            PREC_2B: return 4'd0;
            PREC_4B: return {2'b0, i[0], 1'b0} + {2'b0, j[0], 1'b0};
            default: return {1'b0, i, 1'b0} + {1'b0, j, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/fusion_brick_map.sv
// Combinational slot-array to brick mapper for one 4x4 fusion unit.
module fusion_brick_map
    import bitfusion_pkg::*;
(
    input  prec_e       prec,
    input  logic        signed_x,
    input  logic        signed_y,
    input  logic [31:0] slot_x,
    input  logic [31:0] slot_y,
    output logic [31:0] pe_x,
    output logic [31:0] pe_y,
    output logic [3:0]  sign_x,
    output logic [3:0]  sign_y,
    output logic [63:0] signal
);

    logic [4:0] xo;
    logic [4:0] yo;
    logic [4:0] grp;

    always_comb begin
        pe_x   = '0;
        pe_y   = '0;
        signal = '0;
        xo     = '0;
        yo     = '0;
        grp    = '0;
        for (int b = 0; b < LANES; b++) begin
            // Slot bit offsets feeding brick b = 4i+j.
            case (prec)
                PREC_2B: begin
                    xo = 5'(2 * b);
                    yo = 5'(2 * b);
                end
                PREC_4B: begin
                    grp = 5'(4 * (2 * ((b >> 2) >> 1) + ((b & 3) >> 1)));
                    xo  = grp + 5'(2 * ((b >> 2) & 1));
                    yo  = grp + 5'(2 * (b & 1));
                end
                default: begin
                    xo = 5'(2 * (b >> 2));
                    yo = 5'(2 * (b & 3));
                end
            endcase
            pe_x[2*b +: 2]   = slot_x[xo +: 2];
            pe_y[2*b +: 2]   = slot_y[yo +: 2];
            signal[4*b +: 4] = brick_shift(prec, 2'(b >> 2), 2'(b & 3));
        end
    end

    always_comb begin
        case (prec)
            PREC_2B: begin
                sign_x = {4{signed_x}};
                sign_y = {4{signed_y}};
            end
            PREC_4B: begin
                sign_x = {signed_x, 1'b0, signed_x, 1'b0};
                sign_y = {signed_y, 1'b0, signed_y, 1'b0};
            end
            default: begin
                sign_x = {signed_x, 3'b0};
                sign_y = {signed_y, 3'b0};
            end
        endcase
    end

endmodule

// File: rtl/fusion_feeder.sv
// Operand packer feeding one BitFusion PE with valid/ready on both sides.
// Optional zero-bundle dropping with skip_count: FUSION_FEEDER_ZERO_SKIP_EN.
module fusion_feeder
    import bitfusion_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_prec,
    input  logic        cfg_signed_x,
    input  logic        cfg_signed_y,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    input  logic        in_last,
    output logic        pe_valid,
    input  logic        pe_ready,
    output logic [31:0] pe_x,
    output logic [31:0] pe_y,
    output logic [3:0]  pe_sign_x,
    output logic [3:0]  pe_sign_y,
    output logic [63:0] pe_signal,
    output logic        pe_last,
`ifdef FUSION_FEEDER_ZERO_SKIP_EN
    output logic [15:0] skip_count,
`endif
    output logic        busy
);

    state_e      state_q, state_d;
    logic [3:0]  count_q;
    logic [31:0] slot_x_q, slot_y_q;
    prec_e       prec_q;
    logic        sx_q, sy_q;

    logic        accept, first, closing, skip, emit;
    prec_e       prec_eff;
    logic        sx_eff, sy_eff;
    logic [7:0]  xm, ym;
    logic [4:0]  off;
    logic [31:0] slot_x_n, slot_y_n;
    logic [31:0] map_x, map_y;
    logic [3:0]  map_sx, map_sy;
    logic [63:0] map_sig;

    assign pe_valid = (state_q == HOLD);
    assign in_ready = !pe_valid || pe_ready;
    assign accept   = in_valid && in_ready;
    assign busy     = (count_q != 4'd0) || pe_valid;

    // Config is live only for the first element of a bundle.
    always_comb begin
        first    = (count_q == 4'd0);
        prec_eff = first ? norm_prec(cfg_prec) : prec_q;
        sx_eff   = first ? cfg_signed_x : sx_q;
        sy_eff   = first ? cfg_signed_y : sy_q;
        case (prec_eff)
            PREC_2B: begin
                xm  = {6'b0, in_x[1:0]};
                ym  = {6'b0, in_y[1:0]};
                off = {count_q, 1'b0};
            end
            PREC_4B: begin
                xm  = {4'b0, in_x[3:0]};
                ym  = {4'b0, in_y[3:0]};
                off = {count_q[2:0], 2'b00};
            end
            default: begin
                xm  = in_x;
                ym  = in_y;
                off = 5'd0;
            end
        endcase
        slot_x_n = (first ? 32'd0 : slot_x_q) | (32'(xm) << off);
        slot_y_n = (first ? 32'd0 : slot_y_q) | (32'(ym) << off);
        closing  = in_last || (count_q == last_slot(prec_eff));
    end

    fusion_brick_map u_map (
        .prec     (prec_eff),
        .signed_x (sx_eff),
        .signed_y (sy_eff),
        .slot_x   (slot_x_n),
        .slot_y   (slot_y_n),
        .pe_x     (map_x),
        .pe_y     (map_y),
        .sign_x   (map_sx),
        .sign_y   (map_sy),
        .signal   (map_sig)
    );

`ifdef FUSION_FEEDER_ZERO_SKIP_EN
    assign skip = !in_last && ((map_x == 32'd0) || (map_y == 32'd0));
`else
    assign skip = 1'b0;
`endif

    assign emit = accept && closing && !skip;

    always_comb begin
        state_d = state_q;
        if (emit)
            state_d = HOLD;
        else if (state_q == HOLD && pe_ready)
            state_d = FILL;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FILL;
            count_q   <= '0;
            slot_x_q  <= '0;
            slot_y_q  <= '0;
            prec_q    <= PREC_2B;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            pe_x      <= '0;
            pe_y      <= '0;
            pe_sign_x <= '0;
            pe_sign_y <= '0;
            pe_signal <= '0;
            pe_last   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (first) begin
                    prec_q <= prec_eff;
                    sx_q   <= sx_eff;
                    sy_q   <= sy_eff;
                end
                if (closing) begin
                    count_q  <= '0;
                    slot_x_q <= '0;
                    slot_y_q <= '0;
                end else begin
                    count_q  <= count_q + 4'd1;
                    slot_x_q <= slot_x_n;
                    slot_y_q <= slot_y_n;
                end
            end
            if (emit) begin
                pe_x      <= map_x;
                pe_y      <= map_y;
                pe_sign_x <= map_sx;
                pe_sign_y <= map_sy;
                pe_signal <= map_sig;
                pe_last   <= in_last;
            end
        end
    end

`ifdef FUSION_FEEDER_ZERO_SKIP_EN
    always_ff @(posedge clk) begin
        if (!reset)
            skip_count <= '0;
        else if (accept && closing && skip && skip_count != 16'hFFFF)
            skip_count <= skip_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fusion_feeder.sv
// Directed self-checking bench for fusion_feeder.
module tb_fusion_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cfg_prec;
    logic        cfg_signed_x, cfg_signed_y;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_x, in_y;
    logic        pe_valid, pe_ready, pe_last, busy;
    logic [31:0] pe_x, pe_y;
    logic [3:0]  pe_sign_x, pe_sign_y;
    logic [63:0] pe_signal;
`ifdef FUSION_FEEDER_ZERO_SKIP_EN
    logic [15:0] skip_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fusion_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_prec     (cfg_prec),
        .cfg_signed_x (cfg_signed_x),
        .cfg_signed_y (cfg_signed_y),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_last      (in_last),
        .pe_valid     (pe_valid),
        .pe_ready     (pe_ready),
        .pe_x         (pe_x),
        .pe_y         (pe_y),
        .pe_sign_x    (pe_sign_x),
        .pe_sign_y    (pe_sign_y),
        .pe_signal    (pe_signal),
        .pe_last      (pe_last),
`ifdef FUSION_FEEDER_ZERO_SKIP_EN
        .skip_count   (skip_count),
`endif
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y,
                        input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        pe_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(pe_valid), 64'd0);
    endtask

    function automatic int pe_sum(input logic [31:0] px, input logic [31:0] py,
                                  input logic [3:0] sx, input logic [3:0] sy,
                                  input logic [63:0] sg);
        int s;
        int xv, yv;
        logic [1:0] xf, yf;
        s = 0;
        for (int b = 0; b < 16; b++) begin
            xf = px[2*b +: 2];
            yf = py[2*b +: 2];
            xv = (sx[b/4] && xf[1]) ? int'(xf) - 4 : int'(xf);
            yv = (sy[b%4] && yf[1]) ? int'(yf) - 4 : int'(yf);
            s += xv * yv * (1 << int'(sg[4*b +: 4]));
        end
        return s;
    endfunction

    initial begin
        reset = 1'b0;
        cfg_prec = 2'b00;
        cfg_signed_x = 1'b0;
        cfg_signed_y = 1'b0;
        in_valid = 1'b0;
        in_x = 8'h0;
        in_y = 8'h0;
        in_last = 1'b0;
        pe_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("rst_valid", 64'(pe_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x", 64'(pe_x), 64'd0);
        chk("rst_signal", pe_signal, 64'd0);
        chk("rst_last", 64'(pe_last), 64'd0);
`ifdef FUSION_FEEDER_ZERO_SKIP_EN
        chk("rst_skip", 64'(skip_count), 64'd0);
`endif

        // 8b signed single element, held under backpressure
        cfg_prec = 2'b10;
        cfg_signed_x = 1'b1;
        cfg_signed_y = 1'b1;
        push(8'hFD, 8'h05, 1'b1);
        chk("s8_valid", 64'(pe_valid), 64'd1);
        chk("s8_x", 64'(pe_x), 64'hFFFFFF55);
        chk("s8_y", 64'(pe_y), 64'h05050505);
        chk("s8_sx", 64'(pe_sign_x), 64'h8);
        chk("s8_sy", 64'(pe_sign_y), 64'h8);
        chk("s8_sig", pe_signal, 64'hCA86A86486426420);
        chk("s8_last", 64'(pe_last), 64'd1);
        chk("s8_sum", 64'(pe_sum(pe_x, pe_y, pe_sign_x, pe_sign_y, pe_signal)),
            64'(-15));
        chk("s8_in_ready", 64'(in_ready), 64'd0);
        drain();

        // 2b unsigned full bundle; mid-bundle config change must be ignored
        cfg_prec = 2'b00;
        cfg_signed_x = 1'b0;
        cfg_signed_y = 1'b0;
        for (int k = 0; k < 16; k++) begin
            push(8'(k % 4), 8'h01, 1'b0);
            if (k == 0) begin
                cfg_prec = 2'b10;
                cfg_signed_x = 1'b1;
            end
            if (k < 15) chk("u2_pending", 64'(pe_valid), 64'd0);
        end
        chk("u2_valid", 64'(pe_valid), 64'd1);
        chk("u2_x", 64'(pe_x), 64'hE4E4E4E4);
        chk("u2_y", 64'(pe_y), 64'h55555555);
        chk("u2_sig", pe_signal, 64'd0);
        chk("u2_signs", 64'({pe_sign_x, pe_sign_y}), 64'd0);
        chk("u2_last", 64'(pe_last), 64'd0);
        drain();

        // 4b signed, closed early on the third element
        pe_ready = 1'b0;
        cfg_prec = 2'b01;
        cfg_signed_x = 1'b1;
        cfg_signed_y = 1'b1;
        push(8'hA3, 8'h01, 1'b0);
        push(8'h0F, 8'h02, 1'b0);
        push(8'h07, 8'h0F, 1'b1);
        chk("s4_valid", 64'(pe_valid), 64'd1);
        chk("s4_x", 64'(pe_x), 64'h050FF0FF);
        chk("s4_y", 64'(pe_y), 64'h0F0F2121);
        chk("s4_sx", 64'(pe_sign_x), 64'hA);
        chk("s4_sy", 64'(pe_sign_y), 64'hA);
        chk("s4_sig", pe_signal, 64'h4242202042422020);
        chk("s4_last", 64'(pe_last), 64'd1);

        // Backpressure: offered element waits, then lands the cycle of drain
        cfg_prec = 2'b10;
        cfg_signed_x = 1'b0;
        cfg_signed_y = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x = 8'h12;
            in_y = 8'h34;
            in_last = 1'b1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(pe_valid), 64'd1);
            chk("bp_x", 64'(pe_x), 64'h050FF0FF);
            chk("bp_y", 64'(pe_y), 64'h0F0F2121);
        end
        @(negedge clk);
        pe_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("bp_next_valid", 64'(pe_valid), 64'd1);
        chk("bp_next_x", 64'(pe_x), 64'h005500AA);
        chk("bp_next_y", 64'(pe_y), 64'h34343434);
        chk("bp_next_sx", 64'(pe_sign_x), 64'h0);
        chk("bp_next_last", 64'(pe_last), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_drained", 64'(pe_valid), 64'd0);

        // cfg_prec 11 behaves as 8b
        cfg_prec = 2'b11;
        push(8'h12, 8'h34, 1'b0);
        chk("p3_valid", 64'(pe_valid), 64'd1);
        chk("p3_x", 64'(pe_x), 64'h005500AA);
        chk("p3_sig", pe_signal, 64'hCA86A86486426420);
        chk("p3_last", 64'(pe_last), 64'd0);
        drain();

        // Reset in the middle of a 2b bundle
        cfg_prec = 2'b00;
        for (int k = 0; k < 5; k++) push(8'h03, 8'h03, 1'b0);
        chk("rb_busy", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rb_valid", 64'(pe_valid), 64'd0);
        chk("rb_busy0", 64'(busy), 64'd0);
        for (int k = 0; k < 16; k++) begin
            push((k < 5) ? 8'h00 : 8'h01, 8'h02, 1'b0);
            if (k < 15) chk("rb_pending", 64'(pe_valid), 64'd0);
        end
        chk("rb_new_valid", 64'(pe_valid), 64'd1);
        chk("rb_new_x", 64'(pe_x), 64'h55555400);
        chk("rb_new_y", 64'(pe_y), 64'hAAAAAAAA);
        chk("rb_new_last", 64'(pe_last), 64'd0);
        drain();

        // Zero-operand bundle
        cfg_prec = 2'b10;
        push(8'h00, 8'h07, 1'b0);
`ifdef FUSION_FEEDER_ZERO_SKIP_EN
        chk("zs_valid", 64'(pe_valid), 64'd0);
        chk("zs_count", 64'(skip_count), 64'd1);
        chk("zs_busy", 64'(busy), 64'd0);
        push(8'h00, 8'h07, 1'b1);
        chk("zs_last_valid", 64'(pe_valid), 64'd1);
        chk("zs_last_y", 64'(pe_y), 64'h07070707);
        chk("zs_last_last", 64'(pe_last), 64'd1);
        chk("zs_last_count", 64'(skip_count), 64'd1);
`else
        chk("z_valid", 64'(pe_valid), 64'd1);
        chk("z_x", 64'(pe_x), 64'd0);
        chk("z_y", 64'(pe_y), 64'h07070707);
        chk("z_last", 64'(pe_last), 64'd0);
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
